// File: rtl/ecc_mult_dsp_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : ecc_mult_dsp_seq_if
// Purpose  : Handshake and operand bundle for the sequential ECC MAC unit.
// Revision : 1.0 - initial release
// ============================================================================
interface ecc_mult_dsp_seq_if #(
  parameter int RADIX = 32
);
  logic               zeroize;
  logic               start_i;
  logic               accumulate_i;
  logic [RADIX-1:0]   A_i;
  logic [RADIX-1:0]   B_i;
  logic [2*RADIX-1:0] C_i;
  logic               ready_o;
  logic               valid_o;
  logic [2*RADIX-1:0] P_o;
  logic               carry_o;

  modport master (
    output zeroize, start_i, accumulate_i, A_i, B_i, C_i,
    input  ready_o, valid_o, P_o, carry_o
  );

  modport slave (
    input  zeroize, start_i, accumulate_i, A_i, B_i, C_i,
    output ready_o, valid_o, P_o, carry_o
  );
endinterface
`default_nettype wire

// File: rtl/ecc_mult_dsp_seq.sv
`default_nettype none
// ============================================================================
// Module   : ecc_mult_dsp_seq
// Purpose  : P = A*B + C over four cycles using one RADIX/2 x RADIX/2 multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module ecc_mult_dsp_seq #(
  parameter int RADIX = 32
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  ecc_mult_dsp_seq_if.slave bus
);

  localparam int c_H  = RADIX / 2;
  localparam int c_AW = 2 * RADIX + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PP0  = 3'd1,
    S_PP1  = 3'd2,
    S_PP2  = 3'd3,
    S_PP3  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [RADIX-1:0]   r_a;
  logic [RADIX-1:0]   r_b;
  logic [c_AW-1:0]    r_acc;
  logic [2*RADIX-1:0] r_p;
  logic               r_carry;
  logic               r_valid;

  logic [c_H-1:0]     w_op_a;
  logic [c_H-1:0]     w_op_b;
  logic [2*c_H-1:0]   w_prod;
  logic [c_AW-1:0]    w_pp_ext;
  logic [c_AW-1:0]    w_addend;

  // Shared half-width multiplier; operand halves and alignment chosen by state
  always_comb begin
    w_op_a   = r_a[c_H-1:0];
    w_op_b   = r_b[c_H-1:0];
    w_addend = '0;
    case (r_state)
      S_PP1: w_op_b = r_b[RADIX-1:c_H];
      S_PP2: w_op_a = r_a[RADIX-1:c_H];
      S_PP3: begin
        w_op_a = r_a[RADIX-1:c_H];
        w_op_b = r_b[RADIX-1:c_H];
      end
      default: ;
    endcase
    case (r_state)
      S_PP0:        w_addend = w_pp_ext;
      S_PP1, S_PP2: w_addend = w_pp_ext << c_H;
      S_PP3:        w_addend = w_pp_ext << (2 * c_H);
      default:      w_addend = '0;
    endcase
  end

  assign w_prod   = {{c_H{1'b0}}, w_op_a} * {{c_H{1'b0}}, w_op_b};
  assign w_pp_ext = {{(2 * c_H + 1){1'b0}}, w_prod};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else if (bus.zeroize) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start_i) w_state_nxt = S_PP0;
      S_PP0:   w_state_nxt = S_PP1;
      S_PP1:   w_state_nxt = S_PP2;
      S_PP2:   w_state_nxt = S_PP3;
      S_PP3:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_p     <= '0;
      r_carry <= 1'b0;
      r_valid <= 1'b0;
    end else if (bus.zeroize) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_p     <= '0;
      r_carry <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_a   <= bus.A_i;
            r_b   <= bus.B_i;
            r_acc <= bus.accumulate_i ? {1'b0, bus.C_i} : '0;
          end
        end
        // Accumulator carries one spare bit, so A*B+C never overflows
        S_PP0, S_PP1, S_PP2, S_PP3: r_acc <= r_acc + w_addend;
        S_DONE: begin
          r_p     <= r_acc[2*RADIX-1:0];
          r_carry <= r_acc[2*RADIX];
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o = (r_state == S_IDLE);
  assign bus.valid_o = r_valid;
  assign bus.P_o     = r_p;
  assign bus.carry_o = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_ecc_mult_dsp_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_mult_dsp_seq
// Purpose  : Directed self-checking bench for ecc_mult_dsp_seq at RADIX=32.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecc_mult_dsp_seq;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  ecc_mult_dsp_seq_if #(.RADIX(32)) bus ();

  ecc_mult_dsp_seq #(.RADIX(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one operation; operands on the bus are scrambled after acceptance
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] c, input logic acc,
                       input logic [63:0] ep, input logic ec, input bit poke);
    int first;
    int nvalid;
    logic [63:0] p;
    logic cy;
    first  = 0;
    nvalid = 0;
    p      = '0;
    cy     = 1'b0;
    @(negedge clk);
    bus.A_i = a; bus.B_i = b; bus.C_i = c; bus.accumulate_i = acc;
    bus.start_i = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 1) begin
        chk({tag, "_busy"}, 128'(bus.ready_o), 128'(0));
        bus.A_i = ~a; bus.C_i = ~c; bus.accumulate_i = ~acc;
      end
      bus.start_i = (poke && cyc == 2);
      if (bus.valid_o) begin
        nvalid++;
        if (first == 0) begin
          first = cyc;
          p     = bus.P_o;
          cy    = bus.carry_o;
        end
      end
    end
    chk({tag, "_lat"},   128'(first),  128'(6));
    chk({tag, "_p"},     128'(p),      128'(ep));
    chk({tag, "_carry"}, 128'(cy),     128'(ec));
    chk({tag, "_nvld"},  128'(nvalid), 128'(1));
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input int extra);
    @(negedge clk);
    bus.A_i = a; bus.B_i = b; bus.C_i = 64'h1; bus.accumulate_i = 1'b1;
    bus.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (extra) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic no_valid(input string tag, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.valid_o) cnt++;
    end
    chk(tag, 128'(cnt), 128'(0));
  endtask

  logic [31:0] va [4];
  logic [31:0] vb [4];
  logic [63:0] vc [4];
  logic        vk [4];
  logic [64:0] ve [4];

  initial begin
    int idx;
    int got;
    int last_v;
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    bus.zeroize = 1'b0; bus.start_i = 1'b0; bus.accumulate_i = 1'b0;
    bus.A_i = '0; bus.B_i = '0; bus.C_i = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 128'(bus.ready_o), 128'(1));
    chk("rst_valid", 128'(bus.valid_o), 128'(0));
    chk("rst_p",     128'(bus.P_o),     128'(0));
    chk("rst_carry", 128'(bus.carry_o), 128'(0));
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_ready", 128'(bus.ready_o), 128'(1));
    chk("idle_valid", 128'(bus.valid_o), 128'(0));
    chk("idle_p",     128'(bus.P_o),     128'(0));

    do_op("max_noacc", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hDEADBEEF_00000000, 1'b0,
          64'hFFFFFFFE_00000001, 1'b0, 1'b0);
    do_op("max_acc", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1,
          64'hFFFFFFFE_00000000, 1'b1, 1'b0);
    do_op("mixed_poke", 32'h12345678, 32'h9ABCDEF0, 64'h1, 1'b1,
          64'h0B00EA4E_242D2081, 1'b0, 1'b1);
    do_op("zero_ab", 32'h0, 32'h0, 64'hFFFFFFFF_FFFFFFFF, 1'b1,
          64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0);
    do_op("small_noacc", 32'h2, 32'h3, 64'hFF, 1'b0, 64'h6, 1'b0, 1'b0);

    // Back-to-back with start held high
    va[0] = 32'hDEADBEEF; vb[0] = 32'hCAFEBABE; vc[0] = 64'h01234567_89ABCDEF; vk[0] = 1'b1;
    va[1] = 32'h80000000; vb[1] = 32'h80000000; vc[1] = 64'h80000000_00000000; vk[1] = 1'b1;
    va[2] = 32'hFFFFFFFF; vb[2] = 32'h00000001; vc[2] = 64'hFFFFFFFF_FFFFFFFF; vk[2] = 1'b1;
    va[3] = 32'h00000007; vb[3] = 32'h00000006; vc[3] = 64'h55;                vk[3] = 1'b0;
    for (int i = 0; i < 4; i++)
      ve[i] = 65'(va[i]) * 65'(vb[i]) + (vk[i] ? 65'(vc[i]) : 65'd0);
    idx = 0;
    got = 0;
    last_v = -1;
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      @(negedge clk);
      if (bus.valid_o) begin
        chk("b2b_p",     128'(bus.P_o),     128'(ve[got][63:0]));
        chk("b2b_carry", 128'(bus.carry_o), 128'(ve[got][64]));
        if (got > 0) chk("b2b_gap", 128'(cyc - last_v), 128'(6));
        last_v = cyc;
        got++;
      end
      if (bus.ready_o) begin
        if (idx < 4) begin
          bus.A_i = va[idx]; bus.B_i = vb[idx]; bus.C_i = vc[idx];
          bus.accumulate_i = vk[idx]; bus.start_i = 1'b1;
          idx++;
        end else begin
          bus.start_i = 1'b0;
        end
      end
    end
    bus.start_i = 1'b0;
    chk("b2b_count", 128'(got), 128'(4));

    // Zeroize in PP2
    launch(32'h11111111, 32'h22222222, 2);
    bus.zeroize = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.zeroize = 1'b0;
    chk("zpp2_ready", 128'(bus.ready_o), 128'(1));
    chk("zpp2_p",     128'(bus.P_o),     128'(0));
    chk("zpp2_carry", 128'(bus.carry_o), 128'(0));
    chk("zpp2_valid", 128'(bus.valid_o), 128'(0));
    no_valid("zpp2_novalid", 8);

    // Zeroize together with start in IDLE
    do_op("pre_zidle", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1,
          64'hFFFFFFFE_00000000, 1'b1, 1'b0);
    @(negedge clk);
    bus.A_i = 32'h5; bus.B_i = 32'h5; bus.accumulate_i = 1'b0;
    bus.start_i = 1'b1;
    bus.zeroize = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.zeroize = 1'b0;
    chk("zidle_ready", 128'(bus.ready_o), 128'(1));
    chk("zidle_p",     128'(bus.P_o),     128'(0));
    chk("zidle_carry", 128'(bus.carry_o), 128'(0));
    no_valid("zidle_novalid", 8);

    // Asynchronous reset pulse in PP3
    do_op("pre_rst", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1,
          64'hFFFFFFFE_00000000, 1'b1, 1'b0);
    launch(32'h33333333, 32'h44444444, 3);
    reset_n = 1'b0;
    #1;
    chk("rpp3_ready", 128'(bus.ready_o), 128'(1));
    chk("rpp3_p",     128'(bus.P_o),     128'(0));
    chk("rpp3_carry", 128'(bus.carry_o), 128'(0));
    chk("rpp3_valid", 128'(bus.valid_o), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    no_valid("rpp3_novalid", 8);

    do_op("recover", 32'h0000FFFF, 32'h00010000, 64'h0, 1'b0,
          64'h00000000_FFFF0000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
